led_sequencer: RTL and testbench

Parametrised multi-channel LED pattern sequencer for the TinyFPGA BX designs. It steps through a configurable number of states. Each state lasts a fixed number of prescaled ticks, and each LED channel is independently OFF, ON, BLINK or DIM in each state. The block sits between the board clock and the LED pins. It adds run/pause, one-shot versus loop operation, restart, and state observability for other logic.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/led_seq_tick_gen.sv | 32 +++
 rtl/led_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: per-LED mode codes,
// mode field width and a constant clog2 used to size state and counters.
package led_seq_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd2;
    localparam logic [MODE_W-1:0] MODE_DIM   = 2'd3;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Register width able to hold 0..value-1, never narrower than one bit.
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Prescaler for the LED sequencer: counts 0..TICK_CYCLES-1 while enabled and
// pulses tick in the cycle the count sits at its last value. clear returns
// the count to zero (used for restart); disabling freezes the count.
module led_seq_tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 1 << 22
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = width_of(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign tick = enable && (r_cnt == LAST);

    // Prescale counter; wraps to zero on the tick cycle, holds when disabled.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED pattern sequencer. Steps through NUM_STATES states, each
// lasting TICKS_PER_STATE prescaled ticks; every LED is OFF, BLINK, ON or DIM
// per state as given by PATTERN. Supports run/pause, loop vs one-shot,
// restart, and exposes the current state plus a change strobe.
// Optional feature macro: LED_SEQ_PWM_EN -- adds a free-running 4-bit PWM
// counter so DIM LEDs are driven at DIM_LEVEL/16 duty; without it DIM is ON.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS        = 1,
    parameter int NUM_STATES      = 3,
    parameter int TICK_CYCLES     = 1 << 22,
    parameter int TICKS_PER_STATE = 4,
    parameter logic [NUM_STATES*NUM_LEDS*MODE_W-1:0] PATTERN = 6'b10_01_00,
    parameter int DIM_LEVEL       = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              RUN,
    input  logic                              LOOP,
    input  logic                              RESTART,
    output logic [NUM_LEDS-1:0]               LED,
    output logic [width_of(NUM_STATES)-1:0]   STATE,
    output logic                              STATE_STROBE,
    output logic                              DONE
);

    localparam int SW = width_of(NUM_STATES);
    localparam int TW = width_of(TICKS_PER_STATE);
    localparam int PW = NUM_STATES * NUM_LEDS * MODE_W;
    localparam int IW = width_of(PW);

    localparam logic [SW-1:0] LAST_STATE = SW'(NUM_STATES - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_STATE - 1);

    // Reject configurations the sequencing logic cannot honour.
    if (NUM_STATES < 2 || TICK_CYCLES < 2 || TICKS_PER_STATE < 1 ||
        NUM_LEDS < 1 || DIM_LEVEL < 0 || DIM_LEVEL > 15) begin : g_bad_params
        $error("led_sequencer: parameter out of range");
    end

    logic [SW-1:0]       r_state;
    logic [TW-1:0]       r_tcnt;
    logic                r_phase;
    logic                r_done;
    logic                r_strobe;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_tick;
    logic                w_terminal;
    logic                w_dim;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [IW-1:0]       w_idx;
    logic [MODE_W-1:0]   w_mode;

    // Prescaler only runs while unpaused and not halted after a one-shot.
    led_seq_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (RESTART),
        .enable (RUN && !r_done),
        .tick   (w_tick)
    );

    assign w_terminal = w_tick && (r_tcnt == LAST_TICK);

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm_cnt;

    // Free-running PWM counter; RESTART deliberately leaves it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_dim = (r_pwm_cnt < 4'(DIM_LEVEL));
`else
    assign w_dim = 1'b1;
`endif

    // Sequencing: tick count, blink phase, state advance, one-shot halt.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= '0;
            r_tcnt   <= '0;
            r_phase  <= 1'b0;
            r_done   <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (RESTART) begin
                r_state <= '0;
                r_tcnt  <= '0;
                r_phase <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_terminal) begin
                r_tcnt <= '0;
                if (r_state < LAST_STATE) begin
                    r_state  <= r_state + SW'(1);
                    r_phase  <= 1'b0;
                    r_strobe <= 1'b1;
                end else if (LOOP) begin
                    r_state  <= '0;
                    r_phase  <= 1'b0;
                    r_strobe <= 1'b1;
                end else begin
                    // One-shot end: stay in the last state and halt.
                    r_done <= 1'b1;
                end
            end else if (w_tick) begin
                r_tcnt  <= r_tcnt + TW'(1);
                r_phase <= ~r_phase;
            end
        end
    end

    // Decode each LED's mode for the current state into its drive level.
    always_comb begin
        w_led_next = '0;
        w_idx      = '0;
        w_mode     = MODE_OFF;
        for (int l = 0; l < NUM_LEDS; l++) begin
            w_idx  = IW'(MODE_W * (int'(r_state) * NUM_LEDS + l));
            w_mode = PATTERN[w_idx +: MODE_W];
            case (w_mode)
                MODE_OFF:   w_led_next[l] = 1'b0;
                MODE_BLINK: w_led_next[l] = r_phase;
                MODE_ON:    w_led_next[l] = 1'b1;
                default:    w_led_next[l] = w_dim;
            endcase
        end
    end

    // Registered LED drive, one cycle behind the sequencing registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign LED          = r_led;
    assign STATE        = r_state;
    assign STATE_STROBE = r_strobe;
    assign DONE         = r_done;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed scenarios plus random RUN/LOOP/RESTART/RST
// traffic. A behavioural model tracks the position within the current state's
// dwell and pushes the expected outputs per cycle; a monitor pops and compares.
module tb_led_sequencer;

    localparam int NL  = 2;
    localparam int NS  = 3;
    localparam int TC  = 4;
    localparam int TPS = 4;
    localparam int DL  = 4;
    localparam int D   = TC * TPS;
    localparam logic [11:0] PAT = 12'b1110_1001_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       loop = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] led;
    logic [1:0] state;
    logic       strobe;
    logic       done;

    always #5 clk = ~clk;

    led_sequencer #(
        .NUM_LEDS        (NL),
        .NUM_STATES      (NS),
        .TICK_CYCLES     (TC),
        .TICKS_PER_STATE (TPS),
        .PATTERN         (PAT),
        .DIM_LEVEL       (DL)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .RUN          (run),
        .LOOP         (loop),
        .RESTART      (restart),
        .LED          (led),
        .STATE        (state),
        .STATE_STROBE (strobe),
        .DONE         (done)
    );

    typedef struct packed {
        logic [1:0] led;
        logic [1:0] state;
        logic       strobe;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: state index, cycles spent running in this state, halt flag, PWM.
    int m_st = 0;
    int m_pos = 0;
    bit m_done = 1'b0;
    int m_pwm = 0;

    // Monitor-side timing records, relative to reset release.
    int mon_cyc = 0;
    int strobe_at[$];
    int done_at = -1;

    function automatic logic led_bit(int s, int l, int pos, bit dn, int pwm);
        int  mode;
        logic phase;
        mode  = int'((PAT >> (2 * (s * NL + l))) & 12'd3);
        // Completed ticks in this state; after the one-shot halt every
        // non-terminal tick of the final state has toggled the phase.
        phase = dn ? logic'((TPS - 1) % 2) : logic'((pos / TC) % 2);
        case (mode)
            0: return 1'b0;
            1: return phase;
            2: return 1'b1;
            default: begin
`ifdef LED_SEQ_PWM_EN
                return (pwm < DL);
`else
                return 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic step(input bit r, input bit rs, input bit ru, input bit lp);
        obs_t e;
        @(negedge clk);
        rst = r; restart = rs; run = ru; loop = lp;
        e = '0;
        if (r) begin
            m_st = 0; m_pos = 0; m_done = 1'b0; m_pwm = 0;
        end else begin
            for (int l = 0; l < NL; l++) e.led[l] = led_bit(m_st, l, m_pos, m_done, m_pwm);
            m_pwm = (m_pwm + 1) % 16;
            if (rs) begin
                m_st = 0; m_pos = 0; m_done = 1'b0;
            end else if (ru && !m_done) begin
                if (m_pos == D - 1) begin
                    if (m_st < NS - 1) begin
                        m_st++; m_pos = 0; e.strobe = 1'b1;
                    end else if (lp) begin
                        m_st = 0; m_pos = 0; e.strobe = 1'b1;
                    end else begin
                        m_done = 1'b1;
                    end
                end else begin
                    m_pos++;
                end
            end
            e.state = 2'(m_st);
            e.done  = m_done;
        end
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic run_n(input int n, input bit ru, input bit lp);
        repeat (n) step(0, 0, ru, lp);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against queue.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_cyc = 0;
                strobe_at.delete();
                done_at = -1;
            end else begin
                mon_cyc++;
            end
            if (strobe === 1'b1) strobe_at.push_back(mon_cyc);
            if (done === 1'b1 && done_at < 0) done_at = mon_cyc;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {led, state, strobe, done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL obs t=%0t: got led=%b state=%0d strobe=%b done=%b expected led=%b state=%0d strobe=%b done=%b",
                             $time, a.led, a.state, a.strobe, a.done, e.led, e.state, e.strobe, e.done);
                end
            end
        end
    end

    initial begin
        bit lp;

        // Loop run: state changes at cycles 16, 32, 48.
        do_reset();
        run_n(60, 1, 1);
        sync();
        chk("loop_strobe_count", strobe_at.size(), 3);
        if (strobe_at.size() == 3) begin
            chk("loop_strobe_0", strobe_at[0], 16);
            chk("loop_strobe_1", strobe_at[1], 32);
            chk("loop_strobe_2", strobe_at[2], 48);
        end

        // One-shot: halts at 48 in the last state, then RESTART.
        do_reset();
        run_n(150, 1, 0);
        sync();
        chk("oneshot_done_cycle", done_at, 48);
        chk("oneshot_strobe_count", strobe_at.size(), 2);
        run_n(5, 1, 1);
        step(0, 1, 1, 0);
        run_n(20, 1, 0);

        // Pause of 7 cycles inside state 1 delays the 1->2 change by 7.
        do_reset();
        run_n(20, 1, 1);
        run_n(7, 0, 1);
        run_n(40, 1, 1);
        sync();
        chk("pause_strobe_count", strobe_at.size(), 3);
        if (strobe_at.size() >= 2) begin
            chk("pause_strobe_0", strobe_at[0], 16);
            chk("pause_strobe_1", strobe_at[1], 39);
        end

        // RST + RESTART on a terminal tick, then RESTART alone on one.
        do_reset();
        run_n(15, 1, 1);
        step(1, 1, 1, 1);
        run_n(20, 1, 1);
        do_reset();
        run_n(15, 1, 1);
        step(0, 1, 1, 1);
        run_n(20, 1, 1);

        // RESTART during a pause holds state 0 until RUN returns.
        run_n(3, 0, 1);
        step(0, 1, 0, 1);
        run_n(5, 0, 1);
        run_n(20, 1, 1);

        // Random traffic.
        lp = 1'b1;
        repeat (3000) begin
            if ($urandom_range(99) < 1) lp = ~lp;
            step(($urandom_range(999) < 3), ($urandom_range(99) < 2),
                 ($urandom_range(99) < 85), lp);
        end

        sync();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
